// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: round-robin AXI4-Stream arbiter that switches owners only
// at frame boundaries. A source is granted when its head beat carries sof, keeps
// the output for H lines, and loses it early if no beat is accepted for T cycles.
module axis_frame_arbiter #(
  parameter int unsigned R = 4,
  parameter int unsigned N = 2,
  parameter int unsigned U = 3,
  parameter int unsigned H = 8,
  parameter int unsigned T = 1024
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [R-1:0]     s_tvalid,
  output logic [R-1:0]     s_tready,
  input  logic [R*8*N-1:0] s_tdata,
  input  logic [R-1:0]     s_tlast,
  input  logic [R*U-1:0]   s_tuser,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [8*N-1:0]   m_tdata,
  output logic             m_tlast,
  output logic [U-1:0]     m_tuser,
  output logic [R-1:0]     grant,
  output logic             busy,
  output logic             abort
);

  localparam int unsigned DW = 8 * N;
  localparam int unsigned PW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned LW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned WW = (T > 1) ? $clog2(T) : 1;

  typedef enum logic {StIdle, StXfer} state_e;

  state_e        r_state, w_state_nxt;
  logic [PW-1:0] r_idx, w_idx_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [LW-1:0] r_line, w_line_nxt;
  logic [WW-1:0] r_wd, w_wd_nxt;

  logic [R-1:0]  w_cand;
  logic          w_found;
  logic [PW-1:0] w_pick;
  logic [PW-1:0] w_idx_inc;
  logic          w_accept;
  logic          w_eof_hit;
  logic          w_wd_exp;

  // Sources whose head beat is a start of frame are arbitration candidates.
  always_comb begin
    w_cand = '0;
    for (int unsigned r = 0; r < R; r++) begin
      w_cand[r] = s_tvalid[r] & s_tuser[r*U];
    end
  end

  // First candidate at or after the round-robin pointer, wrapping modulo R.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (!w_found && w_cand[(32'(r_ptr) + i) % R]) begin
        w_found = 1'b1;
        w_pick  = PW'((32'(r_ptr) + i) % R);
      end
    end
  end

  assign w_idx_inc = (r_idx == PW'(R - 1)) ? '0 : r_idx + 1'b1;
  assign busy      = (r_state == StXfer);

  // Output mux from the owner; idle drains non-sof beats and holds candidates.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tuser  = '0;
    grant    = '0;
    s_tready = s_tvalid & ~w_cand;
    if (busy) begin
      m_tvalid        = s_tvalid[r_idx];
      m_tdata         = s_tdata[32'(r_idx)*DW +: DW];
      m_tlast         = s_tlast[r_idx];
      m_tuser         = s_tuser[32'(r_idx)*U +: U];
      grant           = R'(1) << r_idx;
      s_tready        = '0;
      s_tready[r_idx] = m_tready;
    end
  end

  assign w_accept  = m_tvalid & m_tready;
  assign w_eof_hit = w_accept & m_tlast & (r_line == LW'(H - 1));
  // An accepted beat clears the watchdog, so an end-of-frame beat can never abort.
  assign w_wd_exp  = busy & ~w_accept & (r_wd == WW'(T - 1));
  assign abort     = w_wd_exp;

  // Next-state: arbitration in idle, line counting and watchdog while transferring.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_line_nxt  = r_line;
    w_wd_nxt    = r_wd;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_nxt = StXfer;
          w_idx_nxt   = w_pick;
          w_line_nxt  = '0;
          w_wd_nxt    = '0;
        end
      end
      StXfer: begin
        if (w_eof_hit || w_wd_exp) begin
          w_state_nxt = StIdle;
          w_ptr_nxt   = w_idx_inc;
        end else if (w_accept) begin
          w_wd_nxt = '0;
          if (m_tlast) begin
            w_line_nxt = r_line + 1'b1;
          end
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers; reset drops any frame in flight and rewinds the pointer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_line  <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_line  <= w_line_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter: per-source beat streams drive the
// inputs, expected beats are queued per source, and a monitor predicts the owner
// from the round-robin rule and checks every output cycle.
module tb_axis_frame_arbiter;

  localparam int unsigned R  = 4;
  localparam int unsigned N  = 2;
  localparam int unsigned U  = 3;
  localparam int unsigned H  = 4;
  localparam int unsigned T  = 16;
  localparam int unsigned DW = 8 * N;
  localparam int          SD = 512;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [R-1:0]    s_tvalid, s_tready, s_tlast;
  logic [R*DW-1:0] s_tdata;
  logic [R*U-1:0]  s_tuser;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic [U-1:0]    m_tuser;
  logic [R-1:0]    grant;
  logic            busy, abort;

  always #5 aclk = ~aclk;

  axis_frame_arbiter #(.R(R), .N(N), .U(U), .H(H), .T(T)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .grant    (grant),
    .busy     (busy),
    .abort    (abort)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [2:0]  user;
    logic        fend;
  } beat_t;

  beat_t src_mem [R][SD];
  beat_t exp_mem [R][SD];
  int    src_wr [R];
  int    src_rd [R];
  int    exp_wr [R];
  int    exp_rd [R];

  int vectors = 0;
  int errors = 0;
  int aborts_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // A frame of 'lines' lines (random 1..5 beats each); fewer than H lines = partial.
  task automatic push_frame(input int r, input int lines);
    beat_t b;
    int nb;
    for (int l = 0; l < lines; l++) begin
      nb = int'($urandom_range(1, 5));
      for (int k = 0; k < nb; k++) begin
        b.data = 16'($urandom);
        b.last = (k == nb - 1);
        b.user = {(l == int'(H) - 1) && (k == nb - 1), k == 0, (l == 0) && (k == 0)};
        b.fend = (l == int'(H) - 1) && (k == nb - 1);
        src_mem[r][src_wr[r]] = b;
        src_wr[r]++;
        exp_mem[r][exp_wr[r]] = b;
        exp_wr[r]++;
      end
    end
  endtask

  // Beats without sof: the arbiter must swallow them while idle.
  task automatic push_junk(input int r, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = 16'($urandom);
      b.last = k[0];
      b.user = 3'b010;
      b.fend = 1'b0;
      src_mem[r][src_wr[r]] = b;
      src_wr[r]++;
    end
  endtask

  // Discard the rest of an interrupted frame from the expected stream.
  task automatic drop_rest(input int o);
    while (exp_rd[o] < exp_wr[o] && exp_mem[o][exp_rd[o]].user[0] == 1'b0) begin
      exp_rd[o]++;
    end
  endtask

  function automatic bit all_done();
    for (int r = 0; r < int'(R); r++) begin
      if (exp_rd[r] < exp_wr[r] || src_rd[r] < src_wr[r]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!all_done() && n < lim) begin
      @(negedge aclk);
      n++;
    end
    chk("stream_timeout", 32'(all_done()), 32'd1);
  endtask

  // Source drivers: present queue heads, advance on handshakes, random m_tready.
  initial begin : driver
    logic [R-1:0] hs;
    beat_t        b;
    int           lowrun;
    lowrun   = 0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    m_tready = 1'b0;
    forever begin
      @(negedge aclk);
      hs = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      for (int r = 0; r < int'(R); r++) begin
        if (hs[r]) src_rd[r]++;
        if (src_rd[r] < src_wr[r]) begin
          b = src_mem[r][src_rd[r]];
          s_tvalid[r]          = 1'b1;
          s_tdata[r*DW +: DW]  = b.data;
          s_tlast[r]           = b.last;
          s_tuser[r*U +: U]    = b.user;
        end else begin
          s_tvalid[r]          = 1'b0;
          s_tdata[r*DW +: DW]  = '0;
          s_tlast[r]           = 1'b0;
          s_tuser[r*U +: U]    = '0;
        end
      end
      // Low runs are capped so backpressure alone never trips the watchdog.
      if (lowrun >= 3) m_tready = 1'b1;
      else m_tready = 1'($urandom_range(0, 1));
      lowrun = m_tready ? 0 : lowrun + 1;
    end
  end

  // Monitor: reference model of ownership, drain, watchdog and frame boundaries.
  initial begin : monitor
    bit           mb, pend;
    int           po, owner, ptr, stall, j;
    logic [R-1:0] cand, oh;
    beat_t        e;
    mb = 0; pend = 0; po = 0; owner = 0; ptr = 0; stall = 0;
    forever begin
      @(negedge aclk);
      for (int r = 0; r < int'(R); r++) cand[r] = s_tvalid[r] & s_tuser[r*U];
      if (!aresetn) begin
        if (mb) drop_rest(owner);
        mb = 0; pend = 0; ptr = 0; stall = 0;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_ready", 32'(s_tready), 32'(s_tvalid & ~cand));
        continue;
      end
      if (abort) aborts_seen++;
      if (pend) begin
        mb = 1; owner = po; pend = 0; stall = 0;
      end
      if (!mb) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_mvalid", 32'(m_tvalid), 32'd0);
        chk("idle_mbus", 32'({m_tdata, m_tlast, m_tuser}), 32'd0);
        chk("idle_abort", 32'(abort), 32'd0);
        chk("drain_ready", 32'(s_tready), 32'(s_tvalid & ~cand));
        if (cand != '0) begin
          for (int i = int'(R) - 1; i >= 0; i--) begin
            j = (ptr + i) % int'(R);
            if (cand[j]) po = j;
          end
          pend = 1;
        end
      end else begin
        oh = '0;
        oh[owner] = 1'b1;
        chk("xfer_grant", 32'(grant), 32'(oh));
        chk("xfer_busy", 32'(busy), 32'd1);
        chk("xfer_mvalid", 32'(m_tvalid), 32'(s_tvalid[owner]));
        chk("xfer_ready", 32'(s_tready), 32'(oh & {R{m_tready}}));
        if (m_tvalid && m_tready) begin
          stall = 0;
          chk("xfer_abort", 32'(abort), 32'd0);
          if (exp_rd[owner] >= exp_wr[owner]) begin
            chk("unexpected_beat", 32'(owner), 32'hffff_ffff);
          end else begin
            e = exp_mem[owner][exp_rd[owner]];
            exp_rd[owner]++;
            chk("beat", 32'({m_tdata, m_tlast, m_tuser}), 32'({e.data, e.last, e.user}));
            if (e.fend) begin
              mb = 0;
              ptr = (owner + 1) % int'(R);
            end
          end
        end else begin
          stall++;
          if (stall == int'(T)) begin
            chk("wd_abort", 32'(abort), 32'd1);
            mb = 0;
            ptr = (owner + 1) % int'(R);
            drop_rest(owner);
          end else begin
            chk("wd_quiet", 32'(abort), 32'd0);
          end
        end
      end
    end
  end

  // Scenario sequencing.
  initial begin : main
    int base, n;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_ready", 32'(s_tready), 32'd0);
    @(posedge aclk);
    #2 aresetn = 1'b1;

    // Junk beats on source 1 are drained, then its frame is granted.
    push_junk(1, 5);
    push_frame(1, int'(H));
    wait_done(2000);

    // All sources contending with continuous frames.
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < int'(R); r++) push_frame(r, int'(H));
    end
    wait_done(6000);

    // Source 0 stalls after 3 lines; source 2 has a full frame waiting.
    push_frame(0, 3);
    push_frame(2, int'(H));
    wait_done(2000);
    n = 0;
    while ((busy || aborts_seen == 0) && n < 4 * int'(T)) begin
      @(negedge aclk);
      n++;
    end
    chk("abort_count", 32'(aborts_seen), 32'd1);

    // Reset in the middle of a frame from source 3.
    base = exp_rd[3];
    push_frame(3, int'(H));
    n = 0;
    while (exp_rd[3] < base + 2 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    chk("midframe_reach", 32'(exp_rd[3] >= base + 2), 32'd1);
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("async_mvalid", 32'(m_tvalid), 32'd0);
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    wait_done(500);

    // Pointer is back at 0 after reset: source 1 beats source 3.
    push_frame(3, int'(H));
    push_frame(1, int'(H));
    wait_done(2000);
    repeat (5) @(negedge aclk);
    chk("abort_total", 32'(aborts_seen), 32'd1);
    for (int r = 0; r < int'(R); r++) begin
      chk("src_consumed", 32'(src_rd[r]), 32'(src_wr[r]));
      chk("exp_consumed", 32'(exp_rd[r]), 32'(exp_wr[r]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
